busio: RTL
==========

// Module: busio
// PURPOSE
//  Data-bus interface directly downstream of the memory stage. Turns that stage's combinational
//  load/store request (mem_*) into a registered request/ready transaction on the external data bus.
//  Returns aligned, sign- or zero-extended load data. Holds the pipeline stalled until the transfer completes.
// PARAMETERS
//  MAX_WAIT  255  ready-wait limit in cycles; on expiry the transfer is aborted and bus_fault pulses
//                 (0 = no limit); counter width = $clog2(MAX_WAIT+1)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  reset_n          in   1   asynchronous active-low reset
//  mem_address      in   32  byte address from memory stage (already alignment-checked)
//  mem_store_data   in   32  store data, LSB-justified
//  mem_size         in   2   00 byte, 01 half, 10 word (11 never arrives with load/store set)
//  mem_signed       in   1   sign-extend load result
//  mem_load         in   1   load request (level, held while stalled)
//  mem_store        in   1   store request (level, held while stalled)
//  pipeline_stall   in   1   stall from hazard unit for reasons other than busio
//  mem_load_data    out  32  formatted load result to memory stage
//  bus_stall        out  1   to hazard unit: hold pipeline
//  bus_fault        out  1   one-cycle pulse on MAX_WAIT expiry
//  ext_address      out  32  word address ({mem_address[31:2],2'b00})
//  ext_write_data   out  32  store data replicated to lanes
//  ext_write_strobe out  4   byte enables
//  ext_read_request  out 1   read request, held until ext_ready
//  ext_write_request out 1   write request, held until ext_ready
//  ext_ready        in   1   slave accepts/completes the current request this cycle
//  ext_read_data    in   32  read data, valid with ext_ready
// BEHAVIOUR
//  - Reset: state IDLE; all ext_* outputs, bus_stall, bus_fault, mem_load_data, wait counter = 0.
//    Reset mid-transfer drops the request immediately; no completion is reported.
//  - FSM IDLE -> REQ -> DONE -> IDLE:
//    IDLE: mem_load|mem_store -> bus_stall=1 (combinational); at the edge, register address/data/strobe/request
//          and enter REQ. Requests are otherwise ignored.
//    REQ:  bus_stall=1; requests held stable; counter increments each cycle without ext_ready.
//          ext_ready=1 -> capture ext_read_data (loads); drop requests at the edge; enter DONE.
//          Counter reaching MAX_WAIT -> drop requests; captured data=0; bus_fault=1 for the cycle
//          spent entering DONE; enter DONE.
//    DONE: bus_stall=0; mem_load_data valid from captured data.
//          Stay while pipeline_stall=1, with data held and no reissue; otherwise -> IDLE.
//  - Minimum load/store occupancy: 3 cycles (IDLE detect, REQ with ext_ready=1, DONE).
//  - mem_load and mem_store both set: treat as load, no write.
//  - Invalidate is not observed: a started transfer always completes or times out.
//  - Strobes: byte 4'b0001<<a[1:0]; half a[1]?4'b1100:4'b0011; word 4'b1111.
//  - Write data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - Load: lane selected by the registered a[1:0], then zero- or sign-extended to 32 bits per mem_signed.
//  - mem_load_data = 0 outside DONE; in DONE for a store it is 0.
// STRUCTURE
//  - Shared package bus_pkg: size codes (SIZE_BYTE/HALF/WORD), FSM state encoding, and strobe/replicate functions.
//  - One sub-module: busio_load_align (combinational lane extract + extend), shared with any future fetch path.
// TESTING
//  - lw addr 0x100, ext_ready after 2 waits, data 0xDEADBEEF -> stall 4 cycles total; ext_address 0x100;
//    mem_load_data 0xDEADBEEF in DONE.
//  - lb signed addr 0x103, rdata 0x80xxxxxx -> 0xFFFFFF80; lbu -> 0x00000080; lh addr 0x102 rdata 0xF00Dxxxx
//    -> 0xFFFFF00D.
//  - sb addr 0x201, data 0x000000A5 -> strobe 4'b0010, ext_write_data 0xA5A5A5A5, one write request only.
//  - DONE with pipeline_stall=1 for 3 cycles -> no second request; data held; IDLE after release.
//  - MAX_WAIT=4, ext_ready stuck 0 -> request drops after 4 REQ cycles; bus_fault one pulse; data 0.
//  - reset_n low during REQ -> all outputs 0 asynchronously; after release, a new lw issues cleanly.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus interface: access size codes, the
// transfer FSM encoding, and lane helpers (byte strobes, store replication).
package bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] strobe;
    case (size)
      SIZE_BYTE: strobe = 4'b0001 << offset;
      SIZE_HALF: strobe = offset[1] ? 4'b1100 : 4'b0011;
      default:   strobe = 4'b1111;
    endcase
    return strobe;
  endfunction

  // Copy LSB-justified store data onto every lane the access could hit.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{data[7:0]}};
      SIZE_HALF: lanes = {2{data[15:0]}};
      default:   lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/busio_load_align.sv
// Load data formatter: picks the addressed byte/half/word lane out of a bus
// word and zero- or sign-extends it to 32 bits. Purely combinational.
// Ports:
//   data     in  32  raw bus word
//   offset   in  2   byte offset of the access within the word
//   size     in  2   access size code (bus_pkg SIZE_*)
//   sign_ext in  1   sign-extend narrow results
//   result   out 32  formatted load value
module busio_load_align
  import bus_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = data[7:0];
    case (offset)
      2'd0:    lane_byte = data[7:0];
      2'd1:    lane_byte = data[15:8];
      2'd2:    lane_byte = data[23:16];
      default: lane_byte = data[31:24];
    endcase
    lane_half = offset[1] ? data[31:16] : data[15:0];

    case (size)
      SIZE_BYTE: result = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      SIZE_HALF: result = {{16{sign_ext & lane_half[15]}}, lane_half};
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/busio.sv
// Data-bus interface behind the memory stage. Registers a load/store request
// onto the external request/ready bus, stalls the pipeline until the slave
// answers (or the wait limit expires), and returns formatted load data.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   mem_address/store_data/size/signed   request from the memory stage
//   mem_load, mem_store                  request levels (held while stalled)
//   pipeline_stall                       external hold; keeps busio in DONE
//   mem_load_data                        formatted load result (valid in DONE)
//   bus_stall                            hold pipeline while a transfer is open
//   bus_fault                            one-cycle pulse on wait-limit expiry
//   ext_*                                external data bus
module busio
  import bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic        pipeline_stall,
  output logic [31:0] mem_load_data,
  output logic        bus_stall,
  output logic        bus_fault,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  output logic        ext_read_request,
  output logic        ext_write_request,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data
);

  // MAX_WAIT = 0 disables the limit; keep a 1-bit counter so widths stay legal.
  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      strobe_q, strobe_d;
  logic            rreq_q, rreq_d;
  logic            wreq_q, wreq_d;
  logic            fault_q, fault_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      offset_q, offset_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic            is_load_q, is_load_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            stall;
  logic            timeout;
  logic [31:0]     aligned;

  assign timeout = (MAX_WAIT != 0) && (wait_q == WaitLast);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strobe_d  = strobe_q;
    rreq_d    = rreq_q;
    wreq_d    = wreq_q;
    fault_d   = 1'b0;
    rdata_d   = rdata_q;
    offset_d  = offset_q;
    size_d    = size_q;
    signed_d  = signed_q;
    is_load_d = is_load_q;
    wait_d    = wait_q;
    stall     = 1'b0;

    case (state_q)
      StIdle: begin
        if (mem_load || mem_store) begin
          stall     = 1'b1;
          state_d   = StReq;
          addr_d    = {mem_address[31:2], 2'b00};
          // A simultaneous load and store is treated as a load only.
          is_load_d = mem_load;
          rreq_d    = mem_load;
          wreq_d    = ~mem_load;
          strobe_d  = mem_load ? 4'b0000 : byte_strobe(mem_size, mem_address[1:0]);
          wdata_d   = mem_load ? 32'h0 : replicate(mem_size, mem_store_data);
          offset_d  = mem_address[1:0];
          size_d    = mem_size;
          signed_d  = mem_signed;
          wait_d    = '0;
          rdata_d   = 32'h0;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (ext_ready) begin
          rdata_d = is_load_q ? ext_read_data : 32'h0;
          rreq_d  = 1'b0;
          wreq_d  = 1'b0;
          state_d = StDone;
        end else if (timeout) begin
          rdata_d = 32'h0;
          rreq_d  = 1'b0;
          wreq_d  = 1'b0;
          fault_d = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone: begin
        if (!pipeline_stall) begin
          state_d = StIdle;
          wait_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      strobe_q  <= 4'h0;
      rreq_q    <= 1'b0;
      wreq_q    <= 1'b0;
      fault_q   <= 1'b0;
      rdata_q   <= 32'h0;
      offset_q  <= 2'b00;
      size_q    <= SIZE_BYTE;
      signed_q  <= 1'b0;
      is_load_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strobe_q  <= strobe_d;
      rreq_q    <= rreq_d;
      wreq_q    <= wreq_d;
      fault_q   <= fault_d;
      rdata_q   <= rdata_d;
      offset_q  <= offset_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      is_load_q <= is_load_d;
      wait_q    <= wait_d;
    end
  end

  busio_load_align u_load_align (
    .data     (rdata_q),
    .offset   (offset_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .result   (aligned)
  );

  // Stall is combinational from IDLE; gate with reset so outputs read 0 in reset.
  assign bus_stall         = stall & reset_n;
  // Registered: the fault pulse is visible during the first DONE cycle.
  assign bus_fault         = fault_q;
  assign mem_load_data     = (state_q == StDone && is_load_q) ? aligned : 32'h0;
  assign ext_address       = addr_q;
  assign ext_write_data    = wdata_q;
  assign ext_write_strobe  = strobe_q;
  assign ext_read_request  = rreq_q;
  assign ext_write_request = wreq_q;

endmodule
